// File: rtl/fixed_div_ctrl.sv
// Valid/ready front-end for the sequential sign-magnitude fixed-point divider.
// Optional divide-by-zero bypass enabled by defining FIXDIV_DIVZERO_EN.
module fixed_div_ctrl #(
    parameter int unsigned Q = 16,
    parameter int unsigned N = 32
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] in_a_i,
    input  logic [N-1:0] in_b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_q_o,
    output logic         out_dz_o,
    output logic         div_valid_o,
    output logic [N-1:0] div_a_o,
    output logic [N-1:0] div_b_o,
    input  logic         div_ready_i,
    input  logic [N-1:0] div_result_i
);

    localparam logic [N-2:0] MAG_MAX = {(N-1){1'b1}};
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
`ifdef FIXDIV_DIVZERO_EN
    localparam logic [1:0] S_ZERO = 2'd3;
`endif

    // The fractional width must leave room for the sign and an integer part.
    if (Q >= N - 1) begin : g_bad_q
        $error("fixed_div_ctrl: Q must be smaller than N-1");
    end

    // Two's complement to sign-magnitude; the most negative value saturates.
    function automatic logic [N-1:0] to_sm(input logic [N-1:0] x);
        logic [N-1:0] neg;
        neg   = -x;
        to_sm = x;
        if (x[N-1]) begin
            if (x[N-2:0] == '0) to_sm = {1'b1, MAG_MAX};
            else                to_sm = {1'b1, neg[N-2:0]};
        end
    endfunction

    // Sign-magnitude to two's complement; a zero magnitude never goes negative.
    function automatic logic [N-1:0] from_sm(input logic [N-1:0] r);
        logic [N-1:0] mag;
        mag     = {1'b0, r[N-2:0]};
        from_sm = mag;
        if (r[N-2:0] == '0) from_sm = '0;
        else if (r[N-1])    from_sm = -mag;
    endfunction

    logic [1:0]   state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_q_q, out_q_d;
    logic         div_valid_q, div_valid_d;
    logic [N-1:0] div_a_q, div_a_d;
    logic [N-1:0] div_b_q, div_b_d;
`ifdef FIXDIV_DIVZERO_EN
    logic         out_dz_q, out_dz_d;
`endif

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        div_valid_d = div_valid_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
`ifdef FIXDIV_DIVZERO_EN
        out_dz_d    = out_dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    div_a_d    = to_sm(in_a_i);
                    div_b_d    = to_sm(in_b_i);
                    in_ready_d = 1'b0;
`ifdef FIXDIV_DIVZERO_EN
                    if (in_b_i == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d     = S_BUSY;
                        div_valid_d = 1'b1;
                    end
`else
                    state_d     = S_BUSY;
                    div_valid_d = 1'b1;
`endif
                end
            end
            S_BUSY: begin
                if (div_ready_i) begin
                    out_q_d     = from_sm(div_result_i);
                    div_valid_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
`ifdef FIXDIV_DIVZERO_EN
                    out_dz_d    = 1'b0;
`endif
                end
            end
`ifdef FIXDIV_DIVZERO_EN
            S_ZERO: begin
                // Saturate toward the dividend's sign; 0/0 yields zero.
                if (div_a_q[N-2:0] == '0) out_q_d = '0;
                else if (div_a_q[N-1])    out_q_d = {1'b1, {(N-2){1'b0}}, 1'b1};
                else                      out_q_d = {1'b0, MAG_MAX};
                out_dz_d    = 1'b1;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
`endif
            S_HOLD: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                div_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            div_valid_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
`ifdef FIXDIV_DIVZERO_EN
            out_dz_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            div_valid_q <= div_valid_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
`ifdef FIXDIV_DIVZERO_EN
            out_dz_q    <= out_dz_d;
`endif
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_q_o     = out_q_q;
    assign div_valid_o = div_valid_q;
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;
`ifdef FIXDIV_DIVZERO_EN
    assign out_dz_o    = out_dz_q;
`else
    assign out_dz_o    = 1'b0;
`endif

endmodule
